regfile_wb_arb: RTL and testbench
=================================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter AW, default 5, SHALL be the register address width.
REQ-002 Parameter DW, default 32, SHALL be the register data width.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: SHALL be the asynchronous, active-high reset.
REQ-005 Ports s0_valid / s0_ready, input / output, 1 each: SHALL be the handshake for writeback source 0 (ALU).
REQ-006 Ports s0_addr / s0_data, input, AW / DW: SHALL be the source 0 destination register and value.
REQ-007 Ports s1_valid, s1_ready, s1_addr, s1_data: SHALL be the same as REQ-005/006 for source 1 (load unit).
REQ-008 Ports rf_we / rf_waddr / rf_wdata, output, 1 / AW / DW: SHALL drive the register-file write port.
REQ-009 Ports rsv_valid / rsv_addr, input, 1 / AW: SHALL be the issue-stage request to mark a destination register pending.
REQ-010 Ports q1_addr / q2_addr, input, AW each: SHALL be the hazard query addresses (the decode read addresses).
REQ-011 Ports q1_busy / q2_busy, output, 1 each: SHALL flag a pending write to the queried register.

Function
REQ-012 Transfer: source n SHALL transfer in any cycle where sn_valid and sn_ready are both high.
REQ-013 Readiness: sn_ready SHALL be combinational and high only for the granted source; the grant SHALL be at most one per cycle.
REQ-014 Valid rule: a source SHALL NOT be granted while its valid is low; with exactly one valid, that source SHALL be granted.
REQ-015 Contention: with both valid, the source not granted most recently SHALL win (round-robin).
REQ-016 Round-robin pointer: SHALL update on every grant; with no grant it SHALL hold.
REQ-017 Write latency: a transfer in cycle N SHALL appear on rf_we/rf_waddr/rf_wdata in cycle N+1, registered.
REQ-018 Idle cycles: with no grant in cycle N, rf_we SHALL be 0 in N+1, and rf_waddr/rf_wdata SHALL hold.
REQ-019 Writes to x0: a transfer with addr 0 SHALL be accepted (ready high), but rf_we SHALL stay 0 for it.
REQ-020 Scoreboard: a 2^AW-bit busy vector; rsv_valid with rsv_addr != 0 SHALL set busy[rsv_addr] at the next edge.
REQ-021 Clear: busy[rf_waddr] SHALL clear at the edge ending a cycle with rf_we high.
REQ-022 Set/clear collision: reserve and clear of the same register in one cycle SHALL leave the bit set.
REQ-023 Query: qk_busy SHALL equal busy[qk_addr] AND NOT (rf_we AND rf_waddr == qk_addr). This matches the register file's same-cycle write bypass.
REQ-024 Query of x0: qk_busy SHALL always be 0 for register 0.
REQ-025 Rejected transfers: the block SHALL NOT check the scoreboard on writeback; a write to a non-busy register SHALL still be performed.

Reset
REQ-026 While rst is high, rf_we, rf_waddr, rf_wdata, the busy vector and the round-robin pointer SHALL be 0 (pointer 0 favours source 0 first).
REQ-027 While rst is high, s0_ready and s1_ready SHALL be 0, and a transfer in flight SHALL be discarded, with no write issued after reset release.

Structure
REQ-028 Package regfile_pkg SHALL hold AW, DW, NREG = 2**AW, and typedef wb_req_t {addr, data}.
REQ-029 The two-input round-robin arbiter SHALL be a sub-module rr_arb2 (req[1:0], grant[1:0], pointer state).
REQ-030 The busy vector and output registers SHALL stay in regfile_wb_arb.

Verification
REQ-031 Test: s0 only, addr 3, data 0xDEADBEEF, in cycle N -> s0_ready=1 in N, rf_we=1/rf_waddr=3/rf_wdata=0xDEADBEEF in N+1, rf_we=0 in N+2.
REQ-032 Test: both valid for 4 cycles after reset (s0 addr 1, s1 addr 2) -> grants s0, s1, s0, s1; rf_waddr sequence 1, 2, 1, 2.
REQ-033 Test: s1 write to addr 0, data 0x5 -> s1_ready=1, rf_we stays 0.
REQ-034 Test: rsv addr 7, then q1_addr=7 -> q1_busy=1; s0 writes 7 -> q1_busy=0 in the rf_we cycle and after.
REQ-035 Test: rsv addr 9 in the same cycle rf_we writes 9 -> busy[9] stays 1 next cycle.
REQ-036 Test: rst asserted mid-transfer (s0 granted, addr 4) -> all outputs 0 asynchronously; no rf_we after release; next contention grants s0 first.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the register-file writeback arbiter slice.
//   AW / DW    : default register address / data widths
//   NREG       : number of architectural registers (2**AW)
//   wb_req_t   : one writeback request (destination register + value)
//   rr_ptr_e   : round-robin pointer, names the source favoured on contention
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    typedef enum logic {
        FAV_S0 = 1'b0,
        FAV_S1 = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_arb_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter. At most one grant per cycle; a lone
//   requester is always granted; on contention the source that was not
//   granted most recently wins. The pointer moves only when a grant is made.
//   clk   : clock
//   rst   : asynchronous active-high reset (pointer favours source 0)
//   req   : request per source, bit n = source n
//   grant : one-hot (or zero) grant, combinational from req and pointer
// ---------------------------------------------------------------------------
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= FAV_S0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr_q == FAV_S0) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // After a grant, favour the other source; hold when nobody was granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = FAV_S1;
        end else if (grant[1]) begin
            ptr_d = FAV_S0;
        end
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// ---------------------------------------------------------------------------
// regfile_wb_arb
//   Arbitrates two writeback sources (ALU, load unit) onto one register-file
//   write port and keeps a pending-write scoreboard for decode hazard checks.
//   clk, rst                    : clock, asynchronous active-high reset
//   s0_valid/ready/addr/data    : writeback source 0 (ALU) handshake + payload
//   s1_valid/ready/addr/data    : writeback source 1 (load unit)
//   rf_we/rf_waddr/rf_wdata     : registered register-file write port
//   rsv_valid/rsv_addr          : issue-stage reservation of a destination
//   q1_addr/q2_addr             : hazard query addresses (decode reads)
//   q1_busy/q2_busy             : pending write to the queried register
// ---------------------------------------------------------------------------
module regfile_wb_arb #(
    parameter int unsigned AW = regfile_pkg::AW,
    parameter int unsigned DW = regfile_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [AW-1:0] s0_addr,
    input  logic [DW-1:0] s0_data,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_addr,
    input  logic [DW-1:0] s1_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] q1_addr,
    input  logic [AW-1:0] q2_addr,
    output logic          q1_busy,
    output logic          q2_busy
);

    localparam int unsigned NREG = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_sel_t;

    logic [1:0]      req;
    logic [1:0]      grant;
    wb_sel_t         sel;

    logic            we_q,    we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] busy_q,  busy_d;

    // Requests are masked during reset so neither ready can rise and an
    // in-flight transfer cannot be captured.
    assign req = {s1_valid, s0_valid} & {2{~rst}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    assign s0_ready = grant[0];
    assign s1_ready = grant[1];

    always_comb begin
        sel.addr = s0_addr;
        sel.data = s0_data;
        if (grant[1]) begin
            sel.addr = s1_addr;
            sel.data = s1_data;
        end
    end

    // A transfer to x0 is accepted but produces no write; the port keeps
    // its last real address/data in that case as on idle cycles.
    always_comb begin
        we_d    = (grant != 2'b00) && (sel.addr != '0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (we_d) begin
            waddr_d = sel.addr;
            wdata_d = sel.data;
        end
    end

    // Clear first, then set: a reservation colliding with the completing
    // write to the same register leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

    // The write landing this cycle is bypassed by the register file, so it
    // no longer counts as a hazard.
    assign q1_busy = (q1_addr != '0) && busy_q[q1_addr] &&
                     !(we_q && (waddr_q == q1_addr));
    assign q2_busy = (q2_addr != '0) && busy_q[q2_addr] &&
                     !(we_q && (waddr_q == q2_addr));

endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s1_valid, rsv_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr, s1_addr, rsv_addr, q1_addr, q2_addr;
    logic [31:0] s0_data, s1_data;
    logic        rf_we, q1_busy, q2_busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arb #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy)
    );

    typedef struct {
        bit          s0v;
        logic [4:0]  s0a;
        logic [31:0] s0d;
        bit          s1v;
        logic [4:0]  s1a;
        logic [31:0] s1d;
        bit          rv;
        logic [4:0]  ra;
        logic [4:0]  q1;
        logic [4:0]  q2;
    } in_t;

    typedef struct {
        in_t         in;
        bit          e_s0r;
        bit          e_s1r;
        bit          e_we;
        bit          chk_wd;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    // Reference model: architectural view of the block.
    int          last_g;     // -1 none yet, else source granted most recently
    bit          busy_m[32];
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          wd_known;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit q_exp(input logic [4:0] q);
        return (q != 0) && busy_m[q] && !(m_we && m_wa == q);
    endfunction

    function automatic in_t mk(input bit s0v, input logic [4:0] s0a, input logic [31:0] s0d,
                               input bit s1v, input logic [4:0] s1a, input logic [31:0] s1d,
                               input bit rv, input logic [4:0] ra,
                               input logic [4:0] q1, input logic [4:0] q2);
        in_t r;
        r.s0v = s0v; r.s0a = s0a; r.s0d = s0d;
        r.s1v = s1v; r.s1a = s1a; r.s1d = s1d;
        r.rv = rv; r.ra = ra; r.q1 = q1; r.q2 = q2;
        return r;
    endfunction

    task automatic drive(input in_t in);
        s0_valid = in.s0v; s0_addr = in.s0a; s0_data = in.s0d;
        s1_valid = in.s1v; s1_addr = in.s1a; s1_data = in.s1d;
        rsv_valid = in.rv; rsv_addr = in.ra;
        q1_addr = in.q1; q2_addr = in.q2;
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        last_g = -1; m_we = 0; m_wa = '0; m_wd = '0; wd_known = 1;
    endtask

    // One clock: drive at negedge, check combinational outputs, take the
    // edge, advance the model, check registered outputs.
    task automatic step(input in_t in);
        int g;
        logic [4:0]  a;
        logic [31:0] d;
        @(negedge clk);
        drive(in);
        #1;
        if (in.s0v && in.s1v) g = (last_g == 0) ? 1 : 0;
        else if (in.s0v)      g = 0;
        else if (in.s1v)      g = 1;
        else                  g = -1;
        chk("s0_ready", s0_ready, g == 0);
        chk("s1_ready", s1_ready, g == 1);
        chk("q1_busy", q1_busy, q_exp(in.q1));
        chk("q2_busy", q2_busy, q_exp(in.q2));
        @(posedge clk);
        if (m_we) busy_m[m_wa] = 1'b0;
        if (in.rv && in.ra != 0) busy_m[in.ra] = 1'b1;
        if (g >= 0) begin
            a = (g == 1) ? in.s1a : in.s0a;
            d = (g == 1) ? in.s1d : in.s0d;
            last_g = g;
            m_we = (a != 0);
            if (m_we) begin m_wa = a; m_wd = d; wd_known = 1; end
            else wd_known = 0;
        end else begin
            m_we = 0;
        end
        #1;
        chk("rf_we", rf_we, m_we);
        if (wd_known) begin
            chk("rf_waddr", rf_waddr, m_wa);
            chk("rf_wdata", rf_wdata, m_wd);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(mk(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd3, 5'd3, 5'd1));
        #1;
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        @(posedge clk); #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_q1_busy", q1_busy, 0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        model_reset();
    endtask

    vec_t vecs[$];
    in_t  idle;

    initial begin
        rst = 1'b0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        model_reset();

        // Table: contention after reset, single-source write, write to x0.
        vecs.push_back('{mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0), 1, 0, 1, 1, 5'd1, 32'h11});
        vecs.push_back('{mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0), 0, 1, 1, 1, 5'd2, 32'h22});
        vecs.push_back('{mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0), 1, 0, 1, 1, 5'd1, 32'h11});
        vecs.push_back('{mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0), 0, 1, 1, 1, 5'd2, 32'h22});
        vecs.push_back('{idle,                                                 0, 0, 0, 1, 5'd2, 32'h22});
        vecs.push_back('{mk(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0),       1, 0, 1, 1, 5'd3, 32'hDEADBEEF});
        vecs.push_back('{idle,                                                 0, 0, 0, 1, 5'd3, 32'hDEADBEEF});
        vecs.push_back('{mk(0, 0, 0, 1, 5'd0, 32'h5, 0, 0, 0, 0),              0, 1, 0, 0, 5'd0, 32'h0});
        vecs.push_back('{idle,                                                 0, 0, 0, 0, 5'd0, 32'h0});

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].in);
            // step() leaves us #1 after the edge with this row's inputs still
            // applied, so ready reflects the updated pointer; recheck outputs
            // against the table's own expectations.
            chk($sformatf("tbl%0d_rf_we", i), rf_we, vecs[i].e_we);
            if (vecs[i].chk_wd) begin
                chk($sformatf("tbl%0d_rf_waddr", i), rf_waddr, vecs[i].e_wa);
                chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, vecs[i].e_wd);
            end
        end

        // Reserve 7, query it, write it back: busy drops in the rf_we cycle.
        step(mk(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0));
        chk("r7_busy_before", q1_busy, 1);
        step(mk(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 5'd7, 5'd7));
        chk("r7_busy_wecycle", q1_busy, 0);
        chk("r7_busy_wecycle_q2", q2_busy, 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0));
        chk("r7_busy_after", q1_busy, 0);

        // Reserve 9 in the same cycle rf_we writes 9: bit must survive.
        step(mk(1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 5'd0, 5'd0));
        step(mk(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0));
        chk("r9_collision_busy", q1_busy, 1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd9));
        chk("r9_collision_busy_q2", q2_busy, 1);

        // Reset in the middle of an s0 transfer.
        do_reset();
        step(mk(0, 0, 0, 0, 0, 0, 1, 5'd6, 5'd0, 5'd0));
        step(mk(1, 5'd5, 32'hCAFE0005, 0, 0, 0, 0, 0, 5'd6, 5'd0));
        @(negedge clk);
        drive(mk(1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 5'd6, 5'd0));
        #1;
        chk("mid_s0_ready_pre", s0_ready, 1);
        chk("mid_q1_busy_pre", q1_busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_s0_ready", s0_ready, 0);
        chk("mid_rf_we", rf_we, 0);
        chk("mid_rf_waddr", rf_waddr, 0);
        chk("mid_rf_wdata", rf_wdata, 0);
        chk("mid_q1_busy", q1_busy, 0);
        @(posedge clk); #1;
        chk("mid_rf_we_hold", rf_we, 0);
        @(negedge clk);
        drive(idle);
        rst = 1'b0;
        model_reset();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd4));
        chk("post_rst_no_we", rf_we, 0);
        step(mk(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB1, 0, 0, 0, 0));
        chk("post_rst_s0_first", rf_waddr, 5'd10);

        // Randomized traffic against the model; small address range so
        // reservations, writebacks and queries collide often.
        for (int i = 0; i < 400; i++) begin
            in_t r;
            r.s0v = ($urandom_range(0, 99) < 60);
            r.s0a = 5'($urandom_range(0, 7));
            r.s0d = $urandom;
            r.s1v = ($urandom_range(0, 99) < 60);
            r.s1a = 5'($urandom_range(0, 7));
            r.s1d = $urandom;
            r.rv  = ($urandom_range(0, 99) < 40);
            r.ra  = 5'($urandom_range(0, 7));
            r.q1  = 5'($urandom_range(0, 7));
            r.q2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step(r);
        end
        step(idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
